// File: rtl/fma_sched_pkg.sv
// Shared types and constants for the FMA issue scheduler.
package fma_sched_pkg;

    localparam int FP_W = 32;
    // Tag id width covers the largest supported requester count (8).
    localparam int ID_W = 3;

    typedef enum logic [1:0] {RUN, DRAIN, HELD} state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    // Scan from the pointer; the first hit wins and later hits are ignored.
    always_comb begin
        logic          found;
        logic [PW-1:0] j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/fma_issue_scheduler.sv
// Shares one fixed-latency FMA pipe among NUM_REQ requesters: round-robin
// issue, latency-matched owner tags, per-requester credit limit, hold/drain.
module fma_issue_scheduler
    import fma_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FMA_LAT = 3,
    parameter int MAX_OUT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][FP_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][FP_W-1:0]  req_b,
    input  logic [NUM_REQ-1:0][FP_W-1:0]  req_c,
    input  logic                          hold,
    output logic                          fma_issue_valid,
    output logic [FP_W-1:0]               fma_a,
    output logic [FP_W-1:0]               fma_b,
    output logic [FP_W-1:0]               fma_c,
    input  logic [FP_W-1:0]               fma_result,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [FP_W-1:0]               rsp_data,
    output logic                          held,
    output logic                          busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    state_t                     state, state_nxt;
    logic                       run_ok;
    logic [PW-1:0]              rr_ptr, gnt_idx;
    logic [NUM_REQ-1:0]         elig, gnt;
    logic [NUM_REQ-1:0][CW-1:0] out_cnt;
    tag_t                       tag_pipe [FMA_LAT];
    tag_t                       tail;

    // A credit returning this cycle can be reused immediately, so a
    // requester sitting at the limit is eligible in its response cycle.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign elig[i] = req_valid[i] && run_ok &&
                         ((out_cnt[i] < MAX_C) || rsp_valid[i]);

        a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
            out_cnt[i] <= MAX_C);
        a_cnt_ovf: assert property (@(posedge clk) disable iff (!rst_n)
            !(out_cnt[i] == MAX_C && gnt[i] && !rsp_valid[i]));
        a_cnt_unf: assert property (@(posedge clk) disable iff (!rst_n)
            !(out_cnt[i] == '0 && rsp_valid[i] && !gnt[i]));
    end

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready       = gnt;
    assign fma_issue_valid = |gnt;
    assign fma_a           = fma_issue_valid ? req_a[gnt_idx] : '0;
    assign fma_b           = fma_issue_valid ? req_b[gnt_idx] : '0;
    assign fma_c           = fma_issue_valid ? req_c[gnt_idx] : '0;

    // Pointer moves past the winner only when something was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (fma_issue_valid)
            rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end

    // Owner tags travel alongside the FMA stages; the tail names the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FMA_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: fma_issue_valid, id: ID_W'(gnt_idx)};
            for (int i = 1; i < FMA_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tail     = tag_pipe[FMA_LAT-1];
    assign rsp_data = fma_result;

    // Decode the tail tag into the one-hot response strobe and the busy flag.
    always_comb begin
        rsp_valid = '0;
        busy      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = tail.valid && (tail.id == ID_W'(i));
        for (int i = 0; i < FMA_LAT; i++)
            busy = busy | tag_pipe[i].valid;
    end

    // Per-requester in-flight count; grant and response together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && !rsp_valid[i])
                    out_cnt[i] <= out_cnt[i] + CW'(1);
                else if (!gnt[i] && rsp_valid[i])
                    out_cnt[i] <= out_cnt[i] - CW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // FSM next state: drain completes once nothing is left in the tag pipe.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (hold) state_nxt = DRAIN;
            DRAIN:   if (!hold)                         state_nxt = RUN;
                     else if (!busy && rsp_valid == '0) state_nxt = HELD;
            HELD:    if (!hold) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM outputs; grants are also gated by reset so they drop asynchronously.
    always_comb begin
        held   = (state == HELD);
        run_ok = rst_n && (state == RUN);
    end

endmodule
